// File: rtl/ul_iq_slot_scheduler.sv
// ---------------------------------------------------------------------------
// ul_iq_slot_scheduler
//
// Uplink scheduler between NCH per-carrier DDC AXI-Stream outputs and the
// CPRI IQ transmit interface. Each channel packs two consecutive DDC samples
// into a pair. On every basic-frame strobe, the pending pair is released into
// that channel's IQ slot. If no pair is ready, the slot is zero and an
// underrun is reported.
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-high reset
//   bf_strobe       one-cycle pulse per CPRI basic frame
//   ch_en           per-channel enable (quasi-static)
//   s_axis_tdata    per channel {Q, I}, channel c at [c*2SW +: 2SW]
//   s_axis_tvalid   per-channel valid
//   s_axis_tready   per-channel ready (decoded from channel state only)
//   iq_tx_i         per channel {I(s1), I(s0)}
//   iq_tx_q         per channel {Q(s1), Q(s0)}
//   iq_tx_valid     pulses the cycle after every bf_strobe
//   underrun        per-channel pulse: a strobe found no complete pair
//   ch_running      per-channel RUN indication
//
// Optional build macro UL_SCHED_STATS_EN adds:
//   stat_clr            clears all statistics counters
//   stat_underrun_cnt   per-channel 16-bit saturating underrun counters
//   stat_stall_cnt      per-channel 16-bit saturating stall-cycle counters
// ---------------------------------------------------------------------------
module ul_iq_slot_scheduler #(
    parameter int NCH = 2,
    parameter int SW  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bf_strobe,
    input  logic [NCH-1:0]      ch_en,
    input  logic [NCH*2*SW-1:0] s_axis_tdata,
    input  logic [NCH-1:0]      s_axis_tvalid,
    output logic [NCH-1:0]      s_axis_tready,
    output logic [NCH*2*SW-1:0] iq_tx_i,
    output logic [NCH*2*SW-1:0] iq_tx_q,
    output logic                iq_tx_valid,
    output logic [NCH-1:0]      underrun,
    output logic [NCH-1:0]      ch_running
`ifdef UL_SCHED_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [NCH*16-1:0]   stat_underrun_cnt,
    output logic [NCH*16-1:0]   stat_stall_cnt
`endif
);

    localparam int DW = 2 * SW;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } ch_state_t;

    logic iq_tx_valid_r;

    // Frame-valid pulse follows every strobe by one cycle, independent of channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iq_tx_valid_r <= 1'b0;
        end else begin
            iq_tx_valid_r <= bf_strobe;
        end
    end

    assign iq_tx_valid = iq_tx_valid_r;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        ch_state_t         state_r, state_nxt_s;
        logic [DW-1:0]     acc_r, acc_nxt_s;
        logic              k_r, k_nxt_s;
        logic [2*DW-1:0]   pend_r, pend_nxt_s;
        logic              pend_vld_r, pend_vld_nxt_s;
        logic [DW-1:0]     slot_i_r, slot_i_nxt_s;
        logic [DW-1:0]     slot_q_r, slot_q_nxt_s;
        logic              underrun_r, underrun_nxt_s;
        logic [DW-1:0]     din_s;
        logic              tready_s;
        logic              accept_s;

        assign din_s    = s_axis_tdata[c*DW +: DW];
        // Ready only in RUN with room: a held s0 plus a full pend means no slot
        // for another sample until the next strobe drains pend.
        assign tready_s = (state_r == ST_RUN) && !(pend_vld_r && k_r);
        assign accept_s = tready_s && s_axis_tvalid[c];

        // Next-state and datapath update for this channel.
        always_comb begin
            state_nxt_s    = state_r;
            acc_nxt_s      = acc_r;
            k_nxt_s        = k_r;
            pend_nxt_s     = pend_r;
            pend_vld_nxt_s = pend_vld_r;
            slot_i_nxt_s   = slot_i_r;
            slot_q_nxt_s   = slot_q_r;
            underrun_nxt_s = 1'b0;
            if (!ch_en[c]) begin
                // Disable wins over everything: drop in-flight data, blank slot.
                state_nxt_s    = ST_OFF;
                acc_nxt_s      = '0;
                k_nxt_s        = 1'b0;
                pend_nxt_s     = '0;
                pend_vld_nxt_s = 1'b0;
                slot_i_nxt_s   = '0;
                slot_q_nxt_s   = '0;
            end else begin
                case (state_r)
                    ST_OFF: begin
                        state_nxt_s = ST_ALIGN;
                    end
                    ST_ALIGN: begin
                        if (bf_strobe) begin
                            // First frame after alignment carries an empty slot.
                            state_nxt_s  = ST_RUN;
                            slot_i_nxt_s = '0;
                            slot_q_nxt_s = '0;
                        end else begin
                            state_nxt_s = ST_ALIGN;
                        end
                    end
                    ST_RUN: begin
                        if (bf_strobe) begin
                            if (pend_vld_r) begin
                                // pend = {s1, s0}, each sample = {Q, I}
                                slot_i_nxt_s   = {pend_r[DW +: SW], pend_r[0 +: SW]};
                                slot_q_nxt_s   = {pend_r[DW+SW +: SW], pend_r[SW +: SW]};
                                pend_vld_nxt_s = 1'b0;
                            end else begin
                                slot_i_nxt_s   = '0;
                                slot_q_nxt_s   = '0;
                                underrun_nxt_s = 1'b1;
                            end
                        end else begin
                            slot_i_nxt_s = slot_i_r;
                        end
                        // A pair can only complete while pend is empty, so this
                        // never collides with the drain above.
                        if (accept_s) begin
                            if (!k_r) begin
                                acc_nxt_s = din_s;
                                k_nxt_s   = 1'b1;
                            end else begin
                                pend_nxt_s     = {din_s, acc_r};
                                pend_vld_nxt_s = 1'b1;
                                k_nxt_s        = 1'b0;
                            end
                        end else begin
                            k_nxt_s = k_r;
                        end
                    end
                    default: begin
                        state_nxt_s = ST_OFF;
                    end
                endcase
            end
        end

        // Channel state and datapath registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_r    <= ST_OFF;
                acc_r      <= '0;
                k_r        <= 1'b0;
                pend_r     <= '0;
                pend_vld_r <= 1'b0;
                slot_i_r   <= '0;
                slot_q_r   <= '0;
                underrun_r <= 1'b0;
            end else begin
                state_r    <= state_nxt_s;
                acc_r      <= acc_nxt_s;
                k_r        <= k_nxt_s;
                pend_r     <= pend_nxt_s;
                pend_vld_r <= pend_vld_nxt_s;
                slot_i_r   <= slot_i_nxt_s;
                slot_q_r   <= slot_q_nxt_s;
                underrun_r <= underrun_nxt_s;
            end
        end

        assign s_axis_tready[c]      = tready_s;
        assign iq_tx_i[c*DW +: DW]   = slot_i_r;
        assign iq_tx_q[c*DW +: DW]   = slot_q_r;
        assign underrun[c]           = underrun_r;
        assign ch_running[c]         = (state_r == ST_RUN);

`ifdef UL_SCHED_STATS_EN
        logic [15:0] ucnt_r;
        logic [15:0] scnt_r;
        logic        stall_s;

        assign stall_s = (state_r == ST_RUN) && s_axis_tvalid[c] && !tready_s;

        // Saturating underrun and stall counters; clear has priority.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ucnt_r <= 16'd0;
                scnt_r <= 16'd0;
            end else if (stat_clr) begin
                ucnt_r <= 16'd0;
                scnt_r <= 16'd0;
            end else begin
                if (underrun_nxt_s && (ucnt_r != 16'hFFFF)) begin
                    ucnt_r <= ucnt_r + 16'd1;
                end
                if (stall_s && (scnt_r != 16'hFFFF)) begin
                    scnt_r <= scnt_r + 16'd1;
                end
            end
        end

        assign stat_underrun_cnt[c*16 +: 16] = ucnt_r;
        assign stat_stall_cnt[c*16 +: 16]    = scnt_r;
`endif
    end

endmodule

// File: tb/tb_ul_iq_slot_scheduler.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ul_iq_slot_scheduler (NCH=2, SW=16).
// A per-channel sample-queue model predicts every registered output; a
// compare process checks the DUT against it each cycle. Directed literal
// checks cover the documented scenarios, then randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_ul_iq_slot_scheduler;

    localparam int NCH = 2;
    localparam int SW  = 16;
    localparam int DW  = 2 * SW;
    localparam int M_OFF = 0, M_ALIGN = 1, M_RUN = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                bf_strobe = 1'b0;
    logic [NCH-1:0]      ch_en = '0;
    logic [NCH*DW-1:0]   s_axis_tdata = '0;
    logic [NCH-1:0]      s_axis_tvalid = '0;
    logic [NCH-1:0]      s_axis_tready;
    logic [NCH*DW-1:0]   iq_tx_i;
    logic [NCH*DW-1:0]   iq_tx_q;
    logic                iq_tx_valid;
    logic [NCH-1:0]      underrun;
    logic [NCH-1:0]      ch_running;
`ifdef UL_SCHED_STATS_EN
    logic                stat_clr = 1'b0;
    logic [NCH*16-1:0]   stat_underrun_cnt;
    logic [NCH*16-1:0]   stat_stall_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    ul_iq_slot_scheduler #(.NCH(NCH), .SW(SW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bf_strobe     (bf_strobe),
        .ch_en         (ch_en),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .iq_tx_i       (iq_tx_i),
        .iq_tx_q       (iq_tx_q),
        .iq_tx_valid   (iq_tx_valid),
        .underrun      (underrun),
        .ch_running    (ch_running)
`ifdef UL_SCHED_STATS_EN
        ,
        .stat_clr          (stat_clr),
        .stat_underrun_cnt (stat_underrun_cnt),
        .stat_stall_cnt    (stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: each channel holds a queue (max 3) of accepted
    // samples. A strobe pops the oldest two if present, else underruns.
    // ------------------------------------------------------------------
    int          m_mode [NCH];
    int          m_cnt  [NCH];
    logic [31:0] m_held [NCH][3];
    logic [31:0] m_i    [NCH];
    logic [31:0] m_q    [NCH];
    logic [NCH-1:0] m_und;
    logic        m_valid;
    int          m_ucnt [NCH];
    int          m_scnt [NCH];
    logic        m_take;
    logic [31:0] m_d;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_und   = '0;
            for (int c = 0; c < NCH; c++) begin
                m_mode[c] = M_OFF;
                m_cnt[c]  = 0;
                m_i[c]    = 32'd0;
                m_q[c]    = 32'd0;
                m_ucnt[c] = 0;
                m_scnt[c] = 0;
            end
        end else begin
            m_valid = bf_strobe;
            for (int c = 0; c < NCH; c++) begin
                m_d    = s_axis_tdata[c*DW +: DW];
                m_take = (m_mode[c] == M_RUN) && s_axis_tvalid[c] && (m_cnt[c] < 3);
`ifdef UL_SCHED_STATS_EN
                if (stat_clr) begin
                    m_scnt[c] = 0;
                end else if ((m_mode[c] == M_RUN) && s_axis_tvalid[c] && (m_cnt[c] == 3) && (m_scnt[c] < 65535)) begin
                    m_scnt[c]++;
                end
`endif
                m_und[c] = 1'b0;
                if (!ch_en[c]) begin
                    m_mode[c] = M_OFF;
                    m_cnt[c]  = 0;
                    m_i[c]    = 32'd0;
                    m_q[c]    = 32'd0;
                end else if (m_mode[c] == M_OFF) begin
                    m_mode[c] = M_ALIGN;
                end else if (m_mode[c] == M_ALIGN) begin
                    if (bf_strobe) begin
                        m_mode[c] = M_RUN;
                        m_i[c]    = 32'd0;
                        m_q[c]    = 32'd0;
                    end
                end else begin
                    if (bf_strobe) begin
                        if (m_cnt[c] >= 2) begin
                            m_i[c] = {m_held[c][1][15:0],  m_held[c][0][15:0]};
                            m_q[c] = {m_held[c][1][31:16], m_held[c][0][31:16]};
                            m_held[c][0] = m_held[c][2];
                            m_cnt[c] = m_cnt[c] - 2;
                        end else begin
                            m_i[c]   = 32'd0;
                            m_q[c]   = 32'd0;
                            m_und[c] = 1'b1;
                        end
                    end
                    if (m_take) begin
                        m_held[c][m_cnt[c]] = m_d;
                        m_cnt[c]++;
                    end
                end
`ifdef UL_SCHED_STATS_EN
                if (stat_clr) begin
                    m_ucnt[c] = 0;
                end else if (m_und[c] && (m_ucnt[c] < 65535)) begin
                    m_ucnt[c]++;
                end
`endif
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("iq_tx_valid", {63'd0, iq_tx_valid}, {63'd0, m_valid});
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("iq_i[%0d]", c), {32'd0, iq_tx_i[c*DW +: DW]}, {32'd0, m_i[c]});
                chk($sformatf("iq_q[%0d]", c), {32'd0, iq_tx_q[c*DW +: DW]}, {32'd0, m_q[c]});
                chk($sformatf("underrun[%0d]", c), {63'd0, underrun[c]}, {63'd0, m_und[c]});
                chk($sformatf("running[%0d]", c), {63'd0, ch_running[c]},
                    {63'd0, (m_mode[c] == M_RUN)});
                chk($sformatf("tready[%0d]", c), {63'd0, s_axis_tready[c]},
                    {63'd0, ((m_mode[c] == M_RUN) && (m_cnt[c] < 3))});
`ifdef UL_SCHED_STATS_EN
                chk($sformatf("ucnt[%0d]", c), {48'd0, stat_underrun_cnt[c*16 +: 16]}, 64'(m_ucnt[c]));
                chk($sformatf("scnt[%0d]", c), {48'd0, stat_stall_cnt[c*16 +: 16]}, 64'(m_scnt[c]));
`endif
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic feed0(input logic v, input logic [31:0] d);
        s_axis_tvalid[0] = v;
        s_axis_tdata[31:0] = d;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_iq_i", {32'd0, iq_tx_i[31:0]}, 64'd0);
        chk("rst_tready", {62'd0, s_axis_tready}, 64'd0);
        chk("rst_running", {62'd0, ch_running}, 64'd0);

        // Channel 0 only: alignment waits for the first strobe.
        ch_en = 2'b01;
        tick();
        tick();
        tick();
        chk("align_tready0", {63'd0, s_axis_tready[0]}, 64'd0);
        bf_strobe = 1'b1;
        tick();
        bf_strobe = 1'b0;
        chk("run_after_strobe", {63'd0, ch_running[0]}, 64'd1);
        chk("valid_after_strobe", {63'd0, iq_tx_valid}, 64'd1);
        chk("align_no_underrun", {63'd0, underrun[0]}, 64'd0);

        // Basic pair.
        feed0(1'b1, 32'h0002_0001); tick();
        feed0(1'b1, 32'h0004_0003); tick();
        feed0(1'b0, 32'h0); tick();
        bf_strobe = 1'b1; tick(); bf_strobe = 1'b0;
        chk("pair_i", {32'd0, iq_tx_i[31:0]}, 64'h0003_0001);
        chk("pair_q", {32'd0, iq_tx_q[31:0]}, 64'h0004_0002);
        chk("pair_valid", {63'd0, iq_tx_valid}, 64'd1);
        chk("ch1_idle_i", {32'd0, iq_tx_i[63:32]}, 64'd0);

        // Backpressure with four back-to-back samples.
        feed0(1'b1, 32'hA001_1001); tick();
        feed0(1'b1, 32'hA002_1002); tick();
        chk("bp_ready_after2", {63'd0, s_axis_tready[0]}, 64'd1);
        feed0(1'b1, 32'hA003_1003); tick();
        chk("bp_ready_drop", {63'd0, s_axis_tready[0]}, 64'd0);
        feed0(1'b1, 32'hA004_1004); tick();
        bf_strobe = 1'b1; tick(); bf_strobe = 1'b0;
        chk("bp_pair12_i", {32'd0, iq_tx_i[31:0]}, 64'h1002_1001);
        chk("bp_pair12_q", {32'd0, iq_tx_q[31:0]}, 64'hA002_A001);
        chk("bp_ready_back", {63'd0, s_axis_tready[0]}, 64'd1);
        tick();
        feed0(1'b0, 32'h0); tick();
        bf_strobe = 1'b1; tick(); bf_strobe = 1'b0;
        chk("bp_pair34_i", {32'd0, iq_tx_i[31:0]}, 64'h1004_1003);
        chk("bp_pair34_q", {32'd0, iq_tx_q[31:0]}, 64'hA004_A003);

        // Underrun, then underrun coinciding with pair completion.
        bf_strobe = 1'b1; tick(); bf_strobe = 1'b0;
        chk("ur_flag", {63'd0, underrun[0]}, 64'd1);
        chk("ur_slot", {32'd0, iq_tx_i[31:0]}, 64'd0);
        feed0(1'b1, 32'hB001_2001); tick();
        chk("ur_pulse_len", {63'd0, underrun[0]}, 64'd0);
        feed0(1'b1, 32'hB002_2002); bf_strobe = 1'b1; tick(); bf_strobe = 1'b0;
        feed0(1'b0, 32'h0);
        chk("ur_same_cycle", {63'd0, underrun[0]}, 64'd1);
        tick();
        bf_strobe = 1'b1; tick(); bf_strobe = 1'b0;
        chk("ur_late_pair_i", {32'd0, iq_tx_i[31:0]}, 64'h2002_2001);
        chk("ur_late_pair_q", {32'd0, iq_tx_q[31:0]}, 64'hB002_B001);
        chk("ur_late_no_flag", {63'd0, underrun[0]}, 64'd0);

        // Disable mid-pair; the stranded s0 must never reappear.
        feed0(1'b1, 32'hC001_3001); tick();
        feed0(1'b0, 32'h0); ch_en = 2'b00; tick();
        chk("dis_running", {63'd0, ch_running[0]}, 64'd0);
        chk("dis_slot", {32'd0, iq_tx_i[31:0]}, 64'd0);
        ch_en = 2'b01; tick();
        tick();
        chk("realign_tready", {63'd0, s_axis_tready[0]}, 64'd0);
        bf_strobe = 1'b1; tick(); bf_strobe = 1'b0;
        chk("realign_running", {63'd0, ch_running[0]}, 64'd1);
        chk("realign_no_ur", {63'd0, underrun[0]}, 64'd0);
        feed0(1'b1, 32'hC002_3002); tick();
        feed0(1'b1, 32'hC003_3003); tick();
        feed0(1'b0, 32'h0);
        bf_strobe = 1'b1; tick(); bf_strobe = 1'b0;
        chk("realign_pair_i", {32'd0, iq_tx_i[31:0]}, 64'h3003_3002);
        chk("realign_pair_q", {32'd0, iq_tx_q[31:0]}, 64'hC003_C002);

`ifdef UL_SCHED_STATS_EN
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        for (int n = 0; n < 3; n++) begin
            bf_strobe = 1'b1; tick(); bf_strobe = 1'b0; tick();
        end
        chk("stat_ur3", {48'd0, stat_underrun_cnt[15:0]}, 64'd3);
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        chk("stat_clr", {48'd0, stat_underrun_cnt[15:0]}, 64'd0);
`endif

        // Randomized traffic on both channels.
        ch_en = 2'b11;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 199) == 0) ch_en[c] = ~ch_en[c];
                s_axis_tvalid[c] = ($urandom_range(0, 9) < 7);
                s_axis_tdata[c*DW +: DW] = $urandom;
            end
            bf_strobe = ($urandom_range(0, 3) == 0);
`ifdef UL_SCHED_STATS_EN
            stat_clr = ($urandom_range(0, 299) == 0);
`endif
            tick();
        end

        // Asynchronous reset mid-traffic: outputs clear without a clock edge.
        #2 rst = 1'b1;
        #1;
        chk("arst_iq_i", iq_tx_i, 64'd0);
        chk("arst_iq_q", iq_tx_q, 64'd0);
        chk("arst_valid", {63'd0, iq_tx_valid}, 64'd0);
        chk("arst_underrun", {62'd0, underrun}, 64'd0);
        chk("arst_running", {62'd0, ch_running}, 64'd0);
        chk("arst_tready", {62'd0, s_axis_tready}, 64'd0);
        tick();
        rst = 1'b0;
        ch_en = 2'b11;
        for (int n = 0; n < 500; n++) begin
            for (int c = 0; c < NCH; c++) begin
                s_axis_tvalid[c] = ($urandom_range(0, 9) < 6);
                s_axis_tdata[c*DW +: DW] = $urandom;
            end
            bf_strobe = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
